// File: rtl/hash_req_arbiter_if.sv
// Request/response bundle between NUM_REQ header parsers, the arbiter and the
// single hash_controller_ip instance. The slave modport is the arbiter's view;
// the master modport is the environment (parsers plus hash table) view.
interface hash_req_arbiter_if #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned IP_ADDR_W = 32
);
    // Requester side
    logic [NUM_REQ-1:0]           req_valid_i;
    logic [NUM_REQ-1:0]           req_insert_i;
    logic [NUM_REQ*IP_ADDR_W-1:0] req_ip_addr_i;
    logic [NUM_REQ-1:0]           req_ready_o;

    // Hash table side
    logic                         insert_val_o;
    logic                         look_up_val_o;
    logic [IP_ADDR_W-1:0]         ip_addr_o;
    logic                         ip_addr_found_i;
    logic                         ip_addr_found_valid_i;

    // Response back to the winning requester
    logic [NUM_REQ-1:0]           rsp_valid_o;
    logic                         rsp_found_o;
    logic                         rsp_timeout_o;

    modport slave (
        input  req_valid_i,
        input  req_insert_i,
        input  req_ip_addr_i,
        input  ip_addr_found_i,
        input  ip_addr_found_valid_i,
        output req_ready_o,
        output insert_val_o,
        output look_up_val_o,
        output ip_addr_o,
        output rsp_valid_o,
        output rsp_found_o,
        output rsp_timeout_o
    );

    modport master (
        output req_valid_i,
        output req_insert_i,
        output req_ip_addr_i,
        output ip_addr_found_i,
        output ip_addr_found_valid_i,
        input  req_ready_o,
        input  insert_val_o,
        input  look_up_val_o,
        input  ip_addr_o,
        input  rsp_valid_o,
        input  rsp_found_o,
        input  rsp_timeout_o
    );
endinterface

// File: rtl/hash_req_arbiter.sv
// Round-robin arbiter sharing one hash_controller_ip between NUM_REQ parsers.
// One operation is in flight at a time; the lookup result (or a timeout) is
// returned as a one-cycle pulse to the requester that won the grant.
module hash_req_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned IP_ADDR_W  = 32,
    parameter int unsigned INSERT_GAP = 2,
    parameter int unsigned LOOKUP_TMO = 63
) (
    input  logic              clk,
    input  logic              rst,
    hash_req_arbiter_if.slave bus
);
    localparam int unsigned IdxW   = $clog2(NUM_REQ);
    localparam int unsigned CntMax = (LOOKUP_TMO > INSERT_GAP) ? LOOKUP_TMO : INSERT_GAP;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] GapLast = CntW'((INSERT_GAP == 0) ? 0 : INSERT_GAP - 1);
    localparam logic [CntW-1:0] TmoLast = CntW'(LOOKUP_TMO - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitLk,
        StInsGap,
        StRespond
    } state_e;

    state_e                 state_q, state_d;
    logic [IdxW-1:0]        rr_q, rr_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic                   ins_q, ins_d;
    logic [IP_ADDR_W-1:0]   addr_q, addr_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   found_q, found_d;
    logic                   tmo_q, tmo_d;

    logic                   grant_found;
    logic [IdxW-1:0]        grant_idx;
    logic [IdxW-1:0]        cand;

    // Pick the first valid requester at or after the round-robin pointer.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IdxW'((32'(rr_q) + i) % NUM_REQ);
            if (!grant_found && bus.req_valid_i[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // State and operation context registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            rr_q    <= '0;
            idx_q   <= '0;
            ins_q   <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
            found_q <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            idx_q   <= idx_d;
            ins_q   <= ins_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            found_q <= found_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next-state logic and all outputs, decoded from the current state.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        idx_d   = idx_q;
        ins_d   = ins_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        found_d = found_q;
        tmo_d   = tmo_q;

        bus.req_ready_o   = '0;
        bus.insert_val_o  = 1'b0;
        bus.look_up_val_o = 1'b0;
        bus.ip_addr_o     = '0;
        bus.rsp_valid_o   = '0;
        bus.rsp_found_o   = 1'b0;
        bus.rsp_timeout_o = 1'b0;

        // Address is presented for the whole operation, not only the strobe cycle.
        if (state_q != StIdle) begin
            bus.ip_addr_o = addr_q;
        end

        unique case (state_q)
            StIdle: begin
                // Ready is gated by reset so nothing is granted while held in reset.
                if (grant_found && rst) begin
                    bus.req_ready_o[grant_idx] = 1'b1;
                end
                if (grant_found) begin
                    idx_d   = grant_idx;
                    ins_d   = bus.req_insert_i[grant_idx];
                    addr_d  = bus.req_ip_addr_i[32'(grant_idx) * IP_ADDR_W +: IP_ADDR_W];
                    rr_d    = (grant_idx == IdxLast) ? '0 : grant_idx + IdxW'(1);
                    state_d = StIssue;
                end
            end

            StIssue: begin
                bus.insert_val_o  = ins_q;
                bus.look_up_val_o = !ins_q;
                cnt_d             = '0;
                found_d           = 1'b0;
                tmo_d             = 1'b0;
                if (!ins_q) begin
                    state_d = StWaitLk;
                end else if (INSERT_GAP == 0) begin
                    state_d = StRespond;
                end else begin
                    state_d = StInsGap;
                end
            end

            StInsGap: begin
                if (cnt_q == GapLast) begin
                    state_d = StRespond;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StWaitLk: begin
                // A result arriving on the last wait cycle beats the timeout.
                if (bus.ip_addr_found_valid_i) begin
                    found_d = bus.ip_addr_found_i;
                    state_d = StRespond;
                end else if (cnt_q == TmoLast) begin
                    tmo_d   = 1'b1;
                    state_d = StRespond;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StRespond: begin
                bus.rsp_valid_o[idx_q] = 1'b1;
                bus.rsp_found_o        = found_q;
                bus.rsp_timeout_o      = tmo_q;
                state_d                = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end
endmodule

// File: tb/tb_hash_req_arbiter.sv
// Self-checking bench for hash_req_arbiter: a small hash-table model answers
// lookups after a programmable delay, and a scoreboard of expected responses
// (requester, found, timeout, latency from grant) is checked by a monitor.
module tb_hash_req_arbiter;
    localparam int unsigned NumReq = 4;
    localparam int unsigned AddrW  = 32;
    localparam int unsigned Gap    = 2;
    localparam int unsigned Tmo    = 63;

    typedef struct {
        int idx;
        bit found;
        bit tmo;
        int lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    hash_req_arbiter_if #(.NUM_REQ(NumReq), .IP_ADDR_W(AddrW)) bus ();

    hash_req_arbiter #(
        .NUM_REQ   (NumReq),
        .IP_ADDR_W (AddrW),
        .INSERT_GAP(Gap),
        .LOOKUP_TMO(Tmo)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int g_cyc = 0;
    int rsp_cnt = 0;
    int lk_cnt = 0;
    int ins_cnt = 0;
    int ready_cnt[NumReq];
    logic [AddrW-1:0] last_issue_addr = '0;
    exp_t sb[$];
    int gq[$];
    bit tbl[logic [AddrW-1:0]];
    int tbl_delay = 0;
    int quota[NumReq];

    always @(posedge clk) cyc <= cyc + 1;

    // Hash table model: answers a lookup tbl_delay cycles into the wait (negative = never).
    initial begin : table_model
        bit pend;
        int left;
        logic [AddrW-1:0] pend_addr;
        pend = 1'b0;
        left = 0;
        pend_addr = '0;
        bus.ip_addr_found_i = 1'b0;
        bus.ip_addr_found_valid_i = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.look_up_val_o && tbl_delay >= 0) begin
                pend = 1'b1;
                left = tbl_delay;
                pend_addr = bus.ip_addr_o;
            end
            if (bus.insert_val_o) tbl[bus.ip_addr_o] = 1'b1;
            @(posedge clk);
            #1;
            bus.ip_addr_found_valid_i = 1'b0;
            bus.ip_addr_found_i = 1'b0;
            if (pend) begin
                if (left == 0) begin
                    bus.ip_addr_found_valid_i = 1'b1;
                    bus.ip_addr_found_i = tbl.exists(pend_addr);
                    pend = 1'b0;
                end else begin
                    left--;
                end
            end
        end
    end

    // Monitor: records grants, pops the scoreboard on every response, checks invariants.
    initial begin : monitor
        exp_t e;
        logic [NumReq-1:0] exp_oh;
        int lat;
        for (int k = 0; k < NumReq; k++) ready_cnt[k] = 0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                for (int k = 0; k < NumReq; k++) begin
                    if (bus.req_ready_o[k]) ready_cnt[k]++;
                    if (bus.req_valid_i[k] && bus.req_ready_o[k]) begin
                        gq.push_back(k);
                        g_cyc = cyc;
                    end
                end
            end
            if (bus.look_up_val_o) lk_cnt++;
            if (bus.insert_val_o) ins_cnt++;
            if (bus.look_up_val_o || bus.insert_val_o) last_issue_addr = bus.ip_addr_o;
            checks++;
            if ((bus.insert_val_o && bus.look_up_val_o) || !$onehot0(bus.rsp_valid_o) ||
                (bus.rsp_valid_o == '0 && (bus.rsp_found_o || bus.rsp_timeout_o))) begin
                errors++;
                $display("FAIL invariant: ins=%b lk=%b rsp_valid=%b found=%b tmo=%b",
                         bus.insert_val_o, bus.look_up_val_o, bus.rsp_valid_o,
                         bus.rsp_found_o, bus.rsp_timeout_o);
            end
            if (bus.rsp_valid_o != '0) begin
                rsp_cnt++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rsp: got rsp_valid=%b, expected no response",
                             bus.rsp_valid_o);
                end else begin
                    e = sb.pop_front();
                    exp_oh = NumReq'(1) << e.idx;
                    lat = cyc - g_cyc;
                    if (bus.rsp_valid_o !== exp_oh || bus.rsp_found_o !== e.found ||
                        bus.rsp_timeout_o !== e.tmo || lat != e.lat) begin
                        errors++;
                        $display("FAIL response: got valid=%b found=%b tmo=%b lat=%0d, expected valid=%b found=%b tmo=%b lat=%0d",
                                 bus.rsp_valid_o, bus.rsp_found_o, bus.rsp_timeout_o, lat,
                                 exp_oh, e.found, e.tmo, e.lat);
                    end
                end
            end
        end
    end

    // Hold valid on every requester with a nonzero quota until each quota is granted.
    task automatic serve(output bit ok);
        int left;
        int hit;
        left = 0;
        for (int k = 0; k < NumReq; k++) begin
            left += quota[k];
            if (quota[k] > 0) bus.req_valid_i[k] = 1'b1;
        end
        for (int n = 0; n < 2000 && left > 0; n++) begin
            hit = -1;
            @(negedge clk);
            for (int k = 0; k < NumReq; k++) begin
                if (bus.req_ready_o[k] && bus.req_valid_i[k]) hit = k;
            end
            @(posedge clk);
            #1;
            if (hit >= 0) begin
                left--;
                quota[hit]--;
                if (quota[hit] == 0) bus.req_valid_i[hit] = 1'b0;
            end
        end
        ok = (left == 0);
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(negedge clk);
            if (sb.size() == 0) ok = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input bit ins, input logic [AddrW-1:0] a);
        bus.req_insert_i[k] = ins;
        bus.req_ip_addr_i[k*AddrW +: AddrW] = a;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid_i = '0;
        bus.req_insert_i = '0;
        bus.req_ip_addr_i = '0;
        #2;
        rst = 1'b0;
        bus.req_valid_i = '1;
        #1;
        checks++;
        if (bus.req_ready_o !== '0) begin
            errors++;
            $display("FAIL reset_ready: got %b, expected 0", bus.req_ready_o);
        end
        checks++;
        if ({bus.insert_val_o, bus.look_up_val_o} !== 2'b00) begin
            errors++;
            $display("FAIL reset_strobes: got %b, expected 00",
                     {bus.insert_val_o, bus.look_up_val_o});
        end
        checks++;
        if ({bus.rsp_valid_o, bus.rsp_found_o, bus.rsp_timeout_o} !== '0) begin
            errors++;
            $display("FAIL reset_rsp: got %b, expected 0",
                     {bus.rsp_valid_o, bus.rsp_found_o, bus.rsp_timeout_o});
        end
        checks++;
        if (bus.ip_addr_o !== '0) begin
            errors++;
            $display("FAIL reset_addr: got %h, expected 0", bus.ip_addr_o);
        end
        bus.req_valid_i = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_round_robin();
        bit ok;
        int order[5] = '{0, 1, 2, 3, 0};
        tbl[32'h1000_0000] = 1'b1;
        tbl[32'h1000_0002] = 1'b1;
        tbl_delay = 0;
        for (int k = 0; k < NumReq; k++) set_req(k, 1'b0, 32'h1000_0000 + k);
        for (int i = 0; i < 5; i++) sb.push_back('{order[i], (order[i] % 2) == 0, 1'b0, 3});
        gq.delete();
        quota = '{2, 1, 1, 1};
        serve(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rr_serve: grants incomplete, got quota left, expected all granted");
        end
        wait_drain(200, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rr_drain: got %0d responses outstanding, expected 0", sb.size());
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= gq.size() || gq[i] != order[i]) begin
                errors++;
                $display("FAIL rr_order[%0d]: got %0d, expected %0d", i,
                         (i < gq.size()) ? gq[i] : -1, order[i]);
            end
        end
    endtask

    task automatic test_single_lookup();
        bit ok;
        int lk0;
        int r0;
        tbl[32'h0A00_0001] = 1'b1;
        tbl_delay = 2;
        lk0 = lk_cnt;
        r0 = ready_cnt[1];
        set_req(1, 1'b0, 32'h0A00_0001);
        sb.push_back('{1, 1'b1, 1'b0, 5});
        quota = '{0, 1, 0, 0};
        serve(ok);
        wait_drain(200, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_drain: got %0d outstanding, expected 0", sb.size());
        end
        checks++;
        if (lk_cnt - lk0 != 1) begin
            errors++;
            $display("FAIL single_lookup_pulse: got %0d cycles, expected 1", lk_cnt - lk0);
        end
        checks++;
        if (ready_cnt[1] - r0 != 1) begin
            errors++;
            $display("FAIL single_ready_pulse: got %0d cycles, expected 1", ready_cnt[1] - r0);
        end
        checks++;
        if (last_issue_addr !== 32'h0A00_0001) begin
            errors++;
            $display("FAIL single_addr: got %h, expected 0a000001", last_issue_addr);
        end
    endtask

    task automatic test_insert_then_lookup();
        bit ok;
        int i0;
        tbl.delete(32'hC0A8_0001);
        i0 = ins_cnt;
        set_req(2, 1'b1, 32'hC0A8_0001);
        sb.push_back('{2, 1'b0, 1'b0, 2 + Gap});
        quota = '{0, 0, 1, 0};
        serve(ok);
        wait_drain(200, ok);
        checks++;
        if (ins_cnt - i0 != 1) begin
            errors++;
            $display("FAIL insert_pulse: got %0d cycles, expected 1", ins_cnt - i0);
        end
        checks++;
        if (last_issue_addr !== 32'hC0A8_0001) begin
            errors++;
            $display("FAIL insert_addr: got %h, expected c0a80001", last_issue_addr);
        end
        tbl_delay = 1;
        set_req(2, 1'b0, 32'hC0A8_0001);
        sb.push_back('{2, 1'b1, 1'b0, 4});
        quota = '{0, 0, 1, 0};
        serve(ok);
        wait_drain(200, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL insert_lookup_drain: got %0d outstanding, expected 0", sb.size());
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int r0;
        tbl[32'h0102_0304] = 1'b1;
        tbl_delay = Tmo + 1;
        set_req(3, 1'b0, 32'h0102_0304);
        sb.push_back('{3, 1'b0, 1'b1, Tmo + 2});
        quota = '{0, 0, 0, 1};
        serve(ok);
        wait_drain(300, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL timeout_drain: got %0d outstanding, expected 0", sb.size());
        end
        r0 = rsp_cnt;
        repeat (6) @(negedge clk);
        checks++;
        if (rsp_cnt != r0) begin
            errors++;
            $display("FAIL late_result: got %0d extra responses, expected 0", rsp_cnt - r0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_coincident();
        bit ok;
        tbl[32'h0505_0505] = 1'b1;
        tbl.delete(32'h0606_0606);
        tbl_delay = Tmo - 1;
        set_req(0, 1'b0, 32'h0505_0505);
        sb.push_back('{0, 1'b1, 1'b0, Tmo + 2});
        quota = '{1, 0, 0, 0};
        serve(ok);
        wait_drain(300, ok);
        set_req(1, 1'b0, 32'h0606_0606);
        sb.push_back('{1, 1'b0, 1'b0, Tmo + 2});
        quota = '{0, 1, 0, 0};
        serve(ok);
        wait_drain(300, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL coincident_drain: got %0d outstanding, expected 0", sb.size());
        end
    endtask

    task automatic test_reset_mid_op();
        bit ok;
        int r0;
        tbl_delay = -1;
        r0 = rsp_cnt;
        set_req(2, 1'b0, 32'h0B00_0002);
        quota = '{0, 0, 1, 0};
        serve(ok);
        @(posedge clk);
        #1;
        set_req(0, 1'b0, 32'h0B00_0000);
        set_req(3, 1'b0, 32'h0B00_0003);
        tbl.delete(32'h0B00_0000);
        tbl[32'h0B00_0003] = 1'b1;
        bus.req_valid_i[0] = 1'b1;
        bus.req_valid_i[3] = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.req_ready_o, bus.insert_val_o, bus.look_up_val_o, bus.rsp_valid_o,
             bus.rsp_found_o, bus.rsp_timeout_o} !== '0 || bus.ip_addr_o !== '0) begin
            errors++;
            $display("FAIL midop_reset_outputs: got ready=%b lk=%b rsp=%b addr=%h, expected all 0",
                     bus.req_ready_o, bus.look_up_val_o, bus.rsp_valid_o, bus.ip_addr_o);
        end
        repeat (2) @(posedge clk);
        #1;
        tbl_delay = 0;
        sb.push_back('{0, 1'b0, 1'b0, 3});
        sb.push_back('{3, 1'b1, 1'b0, 3});
        rst = 1'b1;
        #1;
        checks++;
        if (bus.req_ready_o !== 4'b0001) begin
            errors++;
            $display("FAIL midop_rr_reset: got ready=%b, expected 0001", bus.req_ready_o);
        end
        quota = '{1, 0, 0, 1};
        serve(ok);
        wait_drain(200, ok);
        checks++;
        if (rsp_cnt - r0 != 2) begin
            errors++;
            $display("FAIL midop_rsp_count: got %0d responses, expected 2", rsp_cnt - r0);
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got no finish within time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        test_reset();
        test_round_robin();
        test_single_lookup();
        test_insert_then_lookup();
        test_timeout();
        test_coincident();
        test_reset_mid_op();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL final_drain: got %0d outstanding, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
